axi_write_to_native: RTL

Write-path bridge between the AXI slave port and the controller's native user port. It accepts one AXI write burst (AW + W beats), expands it into one native write command per beat with the computed beat address, and forwards W data/strobes onto the native wdata stream. It returns the B response when the burst completes. It sits directly upstream of the native port and frontend crossbar; the read path is a separate sibling block.

---
 rtl/axi_native_pkg.sv | 29 ++
 rtl/axi_write_to_native_if.sv | 66 ++++++
 rtl/axi_burst_addr_gen.sv | 58 +++++
 rtl/axi_write_to_native.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/axi_native_pkg.sv
// Shared encodings for the AXI <-> native bridges: burst types, response
// codes, the bridge FSM states and the WRAP-length legality check.
package axi_native_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    RESP  = 2'd2
  } state_e;

  // WRAP bursts need a power-of-two beat count of 2, 4, 8 or 16.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    logic ok;
    case (len)
      8'd1, 8'd3, 8'd7, 8'd15: ok = 1'b1;
      default:                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/axi_write_to_native_if.sv
// Bundle of the AXI write channels plus the native command and wdata
// streams. The bridge uses the slave modport; the upstream/downstream
// environment uses master.
interface axi_write_to_native_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256,
  parameter int ID_W   = 1
);
  logic                  axi_aw_valid;
  logic                  axi_aw_ready;
  logic [ADDR_W-1:0]     axi_aw_payload_addr;
  logic [1:0]            axi_aw_payload_burst;
  logic [7:0]            axi_aw_payload_len;
  logic [3:0]            axi_aw_payload_size;
  logic [ID_W-1:0]       axi_aw_payload_id;

  logic                  axi_w_valid;
  logic                  axi_w_ready;
  logic [DATA_W-1:0]     axi_w_payload_data;
  logic [DATA_W/8-1:0]   axi_w_payload_strb;
  logic                  axi_w_last;

  logic                  axi_b_valid;
  logic                  axi_b_ready;
  logic [1:0]            axi_b_payload_resp;
  logic [ID_W-1:0]       axi_b_payload_id;

  logic                  native_cmd_valid;
  logic                  native_cmd_ready;
  logic                  native_cmd_payload_we;
  logic [ADDR_W-1:0]     native_cmd_payload_addr;

  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [DATA_W-1:0]     wdata_payload_data;
  logic [DATA_W/8-1:0]   wdata_payload_we;

  modport slave (
    input  axi_aw_valid, axi_aw_payload_addr, axi_aw_payload_burst,
           axi_aw_payload_len, axi_aw_payload_size, axi_aw_payload_id,
    output axi_aw_ready,
    input  axi_w_valid, axi_w_payload_data, axi_w_payload_strb, axi_w_last,
    output axi_w_ready,
    output axi_b_valid, axi_b_payload_resp, axi_b_payload_id,
    input  axi_b_ready,
    output native_cmd_valid, native_cmd_payload_we, native_cmd_payload_addr,
    input  native_cmd_ready,
    output wdata_valid, wdata_payload_data, wdata_payload_we,
    input  wdata_ready
  );

  modport master (
    output axi_aw_valid, axi_aw_payload_addr, axi_aw_payload_burst,
           axi_aw_payload_len, axi_aw_payload_size, axi_aw_payload_id,
    input  axi_aw_ready,
    output axi_w_valid, axi_w_payload_data, axi_w_payload_strb, axi_w_last,
    input  axi_w_ready,
    input  axi_b_valid, axi_b_payload_resp, axi_b_payload_id,
    output axi_b_ready,
    input  native_cmd_valid, native_cmd_payload_we, native_cmd_payload_addr,
    output native_cmd_ready,
    input  wdata_valid, wdata_payload_data, wdata_payload_we,
    output wdata_ready
  );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Beat (word) address generator shared by the read and write bridges.
// Loads the start word address on AW, steps it on every command handshake.
module axi_burst_addr_gen
  import axi_native_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int BEAT_SHIFT = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [1:0]        load_burst,
  input  logic [7:0]        load_len,
  input  logic              advance,
  output logic [ADDR_W-1:0] word_addr
);

  logic [ADDR_W-1:0] wa_r;
  logic [ADDR_W-1:0] len_mask_r;
  logic [1:0]        mode_r;
  logic [ADDR_W-1:0] wa_next_s;

  // Address register; illegal WRAP lengths and the reserved type fall back to INCR at load.
  always_ff @(posedge clk) begin
    if (rst) begin
      wa_r       <= '0;
      len_mask_r <= '0;
      mode_r     <= BURST_INCR;
    end else if (load) begin
      wa_r       <= load_addr >> BEAT_SHIFT;
      len_mask_r <= ADDR_W'(load_len);
      if (load_burst == BURST_FIXED) begin
        mode_r <= BURST_FIXED;
      end else if ((load_burst == BURST_WRAP) && wrap_len_ok(load_len)) begin
        mode_r <= BURST_WRAP;
      end else begin
        mode_r <= BURST_INCR;
      end
    end else if (advance) begin
      wa_r <= wa_next_s;
    end
  end

  // Next beat address: hold for FIXED, wrap inside the len-aligned window for WRAP, else +1.
  always_comb begin
    wa_next_s = wa_r;
    case (mode_r)
      BURST_FIXED: wa_next_s = wa_r;
      BURST_WRAP:  wa_next_s = (wa_r & ~len_mask_r) |
                               ((wa_r + ADDR_W'(1'b1)) & len_mask_r);
      default:     wa_next_s = wa_r + ADDR_W'(1'b1);
    endcase
  end

  assign word_addr = wa_r;

endmodule

// File: rtl/axi_write_to_native.sv
// AXI write burst -> native write command/data bridge. One burst in flight;
// commands and data beats flow independently and B is returned once both
// streams have moved len+1 beats.
module axi_write_to_native
  import axi_native_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 256,
  parameter int ID_W       = 1,
  parameter int BEAT_SHIFT = 5
) (
  input logic                   sys_clk,
  input logic                   sys_rst,
  axi_write_to_native_if.slave  bus
);

  state_e            state_r;
  state_e            state_next_s;
  logic [7:0]        len_r;
  logic [ID_W-1:0]   id_r;
  logic              err_r;
  logic [8:0]        cmd_cnt_r;
  logic [8:0]        dat_cnt_r;
  logic              out_en_r;

  logic              aw_hs_s;
  logic              cmd_active_s;
  logic              dat_active_s;
  logic              cmd_hs_s;
  logic              dat_hs_s;
  logic              cmd_done_s;
  logic              dat_done_s;
  logic              aw_err_s;
  logic [8:0]        len9_s;
  logic [ADDR_W-1:0] word_addr_s;
  logic [DATA_W-1:0]   wdata_s;
  logic [DATA_W/8-1:0] wstrb_s;

  assign len9_s       = {1'b0, len_r};
  assign aw_hs_s      = bus.axi_aw_valid & bus.axi_aw_ready;
  assign cmd_active_s = (state_r == BURST) && (cmd_cnt_r <= len9_s);
  assign dat_active_s = (state_r == BURST) && (dat_cnt_r <= len9_s);
  assign cmd_hs_s     = cmd_active_s & bus.native_cmd_ready;
  assign dat_hs_s     = dat_active_s & bus.axi_w_valid & bus.wdata_ready;
  assign cmd_done_s   = (cmd_cnt_r > len9_s) | (cmd_hs_s & (cmd_cnt_r == len9_s));
  assign dat_done_s   = (dat_cnt_r > len9_s) | (dat_hs_s & (dat_cnt_r == len9_s));
  assign aw_err_s     = (bus.axi_aw_payload_size != 4'(BEAT_SHIFT)) |
                        (bus.axi_aw_payload_burst == BURST_RSVD) |
                        ((bus.axi_aw_payload_burst == BURST_WRAP) &&
                         !wrap_len_ok(bus.axi_aw_payload_len));
  assign wdata_s      = bus.axi_w_payload_data;
  assign wstrb_s      = bus.axi_w_payload_strb;

  axi_burst_addr_gen #(
    .ADDR_W     (ADDR_W),
    .BEAT_SHIFT (BEAT_SHIFT)
  ) u_addr_gen (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .load       (aw_hs_s),
    .load_addr  (bus.axi_aw_payload_addr),
    .load_burst (bus.axi_aw_payload_burst),
    .load_len   (bus.axi_aw_payload_len),
    .advance    (cmd_hs_s),
    .word_addr  (word_addr_s)
  );

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state: leave BURST only when both streams finish, RESP on B handshake.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (aw_hs_s) state_next_s = BURST;
        else         state_next_s = IDLE;
      end
      BURST: begin
        if (cmd_done_s && dat_done_s) state_next_s = RESP;
        else                          state_next_s = BURST;
      end
      RESP: begin
        if (bus.axi_b_ready) state_next_s = IDLE;
        else                 state_next_s = RESP;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Burst context, beat counters, sticky error and the post-reset AW enable.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      len_r     <= 8'd0;
      id_r      <= '0;
      err_r     <= 1'b0;
      cmd_cnt_r <= 9'd0;
      dat_cnt_r <= 9'd0;
      out_en_r  <= 1'b0;
    end else begin
      out_en_r <= 1'b1;
      if (aw_hs_s) begin
        len_r     <= bus.axi_aw_payload_len;
        id_r      <= bus.axi_aw_payload_id;
        err_r     <= aw_err_s;
        cmd_cnt_r <= 9'd0;
        dat_cnt_r <= 9'd0;
      end else begin
        if (cmd_hs_s) cmd_cnt_r <= cmd_cnt_r + 9'd1;
        if (dat_hs_s) begin
          dat_cnt_r <= dat_cnt_r + 9'd1;
          if (bus.axi_w_last != (dat_cnt_r == len9_s)) err_r <= 1'b1;
        end
      end
    end
  end

  // FSM outputs; W data and strobes pass straight through to the native stream.
  always_comb begin
    bus.axi_aw_ready            = 1'b0;
    bus.axi_w_ready             = 1'b0;
    bus.axi_b_valid             = 1'b0;
    bus.axi_b_payload_resp      = RESP_OKAY;
    bus.axi_b_payload_id        = id_r;
    bus.native_cmd_valid        = 1'b0;
    bus.native_cmd_payload_we   = 1'b1;
    bus.native_cmd_payload_addr = word_addr_s;
    bus.wdata_valid             = 1'b0;
    bus.wdata_payload_data      = wdata_s;
    bus.wdata_payload_we        = wstrb_s;
    case (state_r)
      IDLE: begin
        bus.axi_aw_ready = out_en_r;
      end
      BURST: begin
        bus.native_cmd_valid = cmd_active_s;
        bus.wdata_valid      = dat_active_s & bus.axi_w_valid;
        bus.axi_w_ready      = dat_active_s & bus.wdata_ready;
      end
      RESP: begin
        bus.axi_b_valid        = 1'b1;
        bus.axi_b_payload_resp = err_r ? RESP_SLVERR : RESP_OKAY;
      end
      default: begin
        bus.axi_aw_ready = 1'b0;
      end
    endcase
  end

endmodule
